// File: rtl/ram_seq_ctrl.sv
// Label-RAM port controller: clear sequencer, pipelined saturating increment
// with read-during-write forwarding, and pass-through CGR/SQG writes.
module ram_seq_ctrl #(
    parameter int                   ADDR_LEN = 16,
    parameter int                   DATA_LEN = 8,
    parameter int                   DEPTH    = 2**ADDR_LEN,
    parameter logic [DATA_LEN-1:0]  CLR_VAL  = '0,
    parameter bit                   SAT      = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                clr_start,
    input  logic                BC_mode,
    input  logic                inc_valid,
    input  logic [ADDR_LEN-1:0] XY,
    output logic                inc_ready,
    input  logic                wen_cgr,
    input  logic                wen_sqg,
    input  logic [ADDR_LEN-1:0] BC_rd_addr,
    input  logic [ADDR_LEN-1:0] BC_wr_addr,
    input  logic [DATA_LEN-1:0] ML1XY,
    input  logic [DATA_LEN-1:0] ram_rd_data,
    output logic                wr_en,
    output logic [ADDR_LEN-1:0] wr_addr,
    output logic [DATA_LEN-1:0] wr_data,
    output logic [ADDR_LEN-1:0] rd_addr,
    output logic                clr_busy,
    output logic                clr_done,
    output logic                drop_err
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                clr_done_q, clr_done_d;
    logic                drop_err_q, drop_err_d;
    logic                s1_valid_q, s1_valid_d;
    logic [ADDR_LEN-1:0] s1_addr_q, s1_addr_d;
    logic                lw_valid_q;
    logic [ADDR_LEN-1:0] lw_addr_q;
    logic [DATA_LEN-1:0] lw_data_q;

    logic                pt_wen;
    logic                accept;
    logic [DATA_LEN-1:0] inc_src;
    logic [DATA_LEN-1:0] inc_val;

    // The RAM returns stale data on read-during-write, so the previous
    // cycle's write is forwarded when it hits the stage-1 address.
    assign inc_src = (lw_valid_q && (lw_addr_q == s1_addr_q)) ? lw_data_q : ram_rd_data;
    assign inc_val = (SAT && (&inc_src)) ? inc_src : inc_src + DATA_LEN'(1);

    assign pt_wen   = wen_cgr | wen_sqg;
    assign accept   = inc_valid & inc_ready;
    assign clr_busy = (state_q == CLEAR);
    assign clr_done = clr_done_q;
    assign drop_err = drop_err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        drop_err_d = drop_err_q;
        s1_valid_d = 1'b0;
        s1_addr_d  = s1_addr_q;
        inc_ready  = !RST && (state_q == IDLE) && BC_mode && !clr_start;
        rd_addr    = BC_mode ? XY : BC_rd_addr;
        wr_en      = 1'b0;
        wr_addr    = BC_wr_addr;
        wr_data    = ML1XY;

        case (state_q)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = ADDR_LEN'(cnt_q);
                wr_data = CLR_VAL;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    clr_done_d = 1'b1;
                end
            end
            default: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase

        if (s1_valid_q && (state_q != CLEAR)) begin
            wr_en   = 1'b1;
            wr_addr = s1_addr_q;
            wr_data = inc_val;
        end else if ((state_q == IDLE) && !BC_mode && pt_wen && !RST) begin
            wr_en   = 1'b1;
            wr_addr = BC_wr_addr;
            wr_data = ML1XY;
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_addr_d  = XY;
        end

        if ((state_q == IDLE) && clr_start)
            drop_err_d = 1'b0;
        else if (pt_wen && ((state_q == CLEAR) || BC_mode || s1_valid_q))
            drop_err_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
            drop_err_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            lw_valid_q <= 1'b0;
            lw_addr_q  <= '0;
            lw_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
            drop_err_q <= drop_err_d;
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            lw_valid_q <= wr_en;
            lw_addr_q  <= wr_addr;
            lw_data_q  <= wr_data;
        end
    end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed bench for ram_seq_ctrl with a small behavioural label RAM
// (old data on read-during-write) attached to the controller ports.
module tb_ram_seq_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          CLK;
    logic          RST;
    logic          clr_start, BC_mode, inc_valid;
    logic [AW-1:0] XY;
    logic          inc_ready;
    logic          wen_cgr, wen_sqg;
    logic [AW-1:0] BC_rd_addr, BC_wr_addr;
    logic [DW-1:0] ML1XY;
    logic [DW-1:0] ram_rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic          clr_busy, clr_done, drop_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    ram_seq_ctrl #(
        .ADDR_LEN(AW), .DATA_LEN(DW), .DEPTH(8), .CLR_VAL(8'h00), .SAT(1'b1)
    ) dut (
        .CLK(CLK), .RST(RST), .clr_start(clr_start), .BC_mode(BC_mode),
        .inc_valid(inc_valid), .XY(XY), .inc_ready(inc_ready),
        .wen_cgr(wen_cgr), .wen_sqg(wen_sqg),
        .BC_rd_addr(BC_rd_addr), .BC_wr_addr(BC_wr_addr), .ML1XY(ML1XY),
        .ram_rd_data(ram_rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .clr_busy(clr_busy),
        .clr_done(clr_done), .drop_err(drop_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        ram_rd_data = '0;
    end

    always @(posedge CLK) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        ram_rd_data <= mem[rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    task automatic next_cycle();
        @(negedge CLK);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        clr_start = 0; BC_mode = 0; inc_valid = 0; XY = '0;
        wen_cgr = 0; wen_sqg = 0; BC_rd_addr = '0; BC_wr_addr = '0; ML1XY = '0;
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();

        // Reset state, including gating of wr_en and inc_ready
        next_cycle();
        wen_sqg = 1; BC_wr_addr = 8'h44; ML1XY = 8'h11;
        settle();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_drop_err", drop_err, 0);
        BC_mode = 1; inc_valid = 1; wen_sqg = 0;
        settle();
        chk("rst_inc_ready", inc_ready, 0);
        next_cycle();
        RST = 0;
        idle_inputs();

        // Clear sweep DEPTH=8
        next_cycle();
        clr_start = 1; BC_mode = 1;
        settle();
        chk("clr_start_inc_ready", inc_ready, 0);
        chk("clr_start_busy", clr_busy, 0);
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            clr_start = 0;
            settle();
            chk($sformatf("clr_busy_%0d", i), clr_busy, 1);
            chk($sformatf("clr_wen_%0d", i), wr_en, 1);
            chk($sformatf("clr_addr_%0d", i), wr_addr, i);
            chk($sformatf("clr_data_%0d", i), wr_data, 0);
            if (i == 2) chk("clr_inc_ready", inc_ready, 0);
            if (i == 3) chk("clr_done_mid", clr_done, 0);
        end
        next_cycle();
        idle_inputs();
        settle();
        chk("clr_done_pulse", clr_done, 1);
        chk("clr_busy_after", clr_busy, 0);
        chk("clr_wen_after", wr_en, 0);
        next_cycle();
        settle();
        chk("clr_done_low", clr_done, 0);

        // Pass-through writes: preload RAM[5]=3, then 0x7A to 0x12
        next_cycle();
        wen_cgr = 1; BC_wr_addr = 8'h05; ML1XY = 8'h03;
        settle();
        chk("pt_pre_wen", wr_en, 1);
        chk("pt_pre_addr", wr_addr, 8'h05);
        chk("pt_pre_data", wr_data, 8'h03);
        next_cycle();
        idle_inputs();
        wen_sqg = 1; BC_wr_addr = 8'h12; ML1XY = 8'h7A; BC_rd_addr = 8'h21;
        settle();
        chk("pt_wen", wr_en, 1);
        chk("pt_addr", wr_addr, 8'h12);
        chk("pt_data", wr_data, 8'h7A);
        chk("pt_rd_addr", rd_addr, 8'h21);
        next_cycle();
        idle_inputs();
        settle();
        chk("pt_no_drop", drop_err, 0);

        // Single increment at 5 (RAM holds 3)
        next_cycle();
        BC_mode = 1; inc_valid = 1; XY = 8'h05;
        settle();
        chk("inc1_ready", inc_ready, 1);
        chk("inc1_rd_addr", rd_addr, 8'h05);
        chk("inc1_no_wr", wr_en, 0);
        next_cycle();
        inc_valid = 0;
        settle();
        chk("inc1_wen", wr_en, 1);
        chk("inc1_addr", wr_addr, 8'h05);
        chk("inc1_data", wr_data, 8'h04);

        // Back-to-back increments at 9 (RAM holds 0): 1, 2, 3
        next_cycle();
        inc_valid = 1; XY = 8'h09;
        settle();
        chk("b2b_ready0", inc_ready, 1);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            inc_valid = (i < 3);
            settle();
            chk($sformatf("b2b_wen_%0d", i), wr_en, 1);
            chk($sformatf("b2b_addr_%0d", i), wr_addr, 8'h09);
            chk($sformatf("b2b_data_%0d", i), wr_data, i);
        end

        // Saturation: RAM[9]=0xFE, three increments give FF, FF, FF
        next_cycle();
        idle_inputs();
        wen_cgr = 1; BC_wr_addr = 8'h09; ML1XY = 8'hFE;
        settle();
        chk("sat_pre_data", wr_data, 8'hFE);
        next_cycle();
        idle_inputs();
        BC_mode = 1; inc_valid = 1; XY = 8'h09;
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            inc_valid = (i < 3);
            settle();
            chk($sformatf("sat_wen_%0d", i), wr_en, 1);
            chk($sformatf("sat_data_%0d", i), wr_data, 8'hFF);
        end

        // Pass-through strobe during CLEAR is dropped and sticks
        next_cycle();
        idle_inputs();
        clr_start = 1;
        next_cycle();
        clr_start = 0; wen_sqg = 1; BC_wr_addr = 8'h12; ML1XY = 8'h7A;
        settle();
        chk("drop_clr_addr", wr_addr, 8'h00);
        chk("drop_clr_data", wr_data, 8'h00);
        chk("drop_err_not_yet", drop_err, 0);
        next_cycle();
        idle_inputs();
        settle();
        chk("drop_err_set", drop_err, 1);
        for (int i = 0; i < 8; i++) next_cycle();
        settle();
        chk("drop_err_sticky", drop_err, 1);
        chk("drop_idle_again", clr_busy, 0);
        clr_start = 1;
        settle();
        chk("drop_err_hold_at_start", drop_err, 1);
        next_cycle();
        clr_start = 0;
        settle();
        chk("drop_err_cleared", drop_err, 0);
        for (int i = 0; i < 8; i++) next_cycle();
        settle();
        chk("clr2_done", clr_done, 1);

        // Collision: stage-1 write beats a pass-through strobe (RAM[5]=0)
        next_cycle();
        BC_mode = 1; inc_valid = 1; XY = 8'h05;
        settle();
        chk("col_ready", inc_ready, 1);
        next_cycle();
        BC_mode = 0; inc_valid = 0; wen_cgr = 1; BC_wr_addr = 8'h33; ML1XY = 8'h55;
        settle();
        chk("col_addr", wr_addr, 8'h05);
        chk("col_data", wr_data, 8'h01);
        next_cycle();
        idle_inputs();
        settle();
        chk("col_drop_err", drop_err, 1);
        chk("col_no_wr", wr_en, 0);

        // Reset mid-clear at cnt=3, then restart from address 0
        next_cycle();
        clr_start = 1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            clr_start = 0;
        end
        settle();
        chk("rclr_addr3", wr_addr, 8'h03);
        RST = 1;
        settle();
        chk("rclr_busy", clr_busy, 0);
        chk("rclr_wen", wr_en, 0);
        chk("rclr_drop_err", drop_err, 0);
        next_cycle();
        RST = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk($sformatf("rclr_no_done_%0d", i), clr_done | clr_busy, 0);
            next_cycle();
        end
        clr_start = 1;
        next_cycle();
        clr_start = 0;
        settle();
        chk("rclr_restart_busy", clr_busy, 1);
        chk("rclr_restart_addr", wr_addr, 8'h00);
        next_cycle();
        settle();
        chk("rclr_restart_addr1", wr_addr, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
